inst_sequencer: RTL and testbench

//  Instruction issue stage directly upstream of the PE control/decode block.

---
 rtl/inst_sequencer.sv | 139 +++++++++++++
 tb/tb_inst_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Instruction issue stage: host-loaded program buffer replayed as an inst_v/inst
// stream for a programmable number of passes, followed by a fixed pipeline drain.
module inst_sequencer #(
    parameter int unsigned INST_WIDTH   = 64,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_v,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic                  start,
    input  logic [ADDR_W:0]       num_inst,
    input  logic [7:0]            num_loops,
    input  logic                  stall,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  inst_v,
    output logic [INST_WIDTH-1:0] inst
);

    localparam int unsigned NUM_W = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state, state_n;
    logic [ADDR_W-1:0]     pc, pc_n;
    logic [ADDR_W-1:0]     last, last_n;
    logic [7:0]            loop_idx, loop_idx_n;
    logic [7:0]            loops, loops_n;
    logic [CNT_W-1:0]      drain_cnt, drain_cnt_n;
    logic                  busy_n, done_n, inst_v_n;
    logic [INST_WIDTH-1:0] inst_n;
    logic [NUM_W-1:0]      num_clamped;

    logic [INST_WIDTH-1:0] mem [DEPTH];

    // Program buffer: host writes only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_v && state == IDLE) begin
            mem[load_addr] <= load_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            last      <= '0;
            loop_idx  <= '0;
            loops     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            inst_v    <= 1'b0;
            inst      <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            last      <= last_n;
            loop_idx  <= loop_idx_n;
            loops     <= loops_n;
            drain_cnt <= drain_cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            inst_v    <= inst_v_n;
            inst      <= inst_n;
        end
    end

    assign num_clamped = (num_inst > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : num_inst;

    // Next-state and next-output logic; abort wins over start and stall.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        last_n      = last;
        loop_idx_n  = loop_idx;
        loops_n     = loops;
        drain_cnt_n = drain_cnt;
        inst_n      = inst;
        inst_v_n    = 1'b0;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (num_inst != '0) begin
                        last_n     = ADDR_W'(num_clamped - NUM_W'(1));
                        loops_n    = num_loops;
                        pc_n       = '0;
                        loop_idx_n = '0;
                        state_n    = ISSUE;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (!stall) begin
                    inst_n   = mem[pc];
                    inst_v_n = 1'b1;
                    if (pc != last) begin
                        pc_n = pc + ADDR_W'(1);
                    end else if (loop_idx != loops) begin
                        // Wrap straight into the next pass without a bubble.
                        pc_n       = '0;
                        loop_idx_n = loop_idx + 8'd1;
                    end else begin
                        state_n     = DRAIN;
                        drain_cnt_n = '0;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    drain_cnt_n = drain_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: cycle-exact vector table plus
// directed multi-cycle sequences for looping, meddling, abort and reset.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_v;
    logic [3:0]  load_addr;
    logic [63:0] load_inst;
    logic        start;
    logic [4:0]  num_inst;
    logic [7:0]  num_loops;
    logic        stall;
    logic        abort;
    logic        busy;
    logic        done;
    logic        inst_v;
    logic [63:0] inst;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ADD = 64'h8000_0000_0100_0000;
    localparam logic [63:0] SUB = 64'h8000_0000_0200_0011;
    localparam logic [63:0] MUL = 64'h0000_0000_0300_0022;

    logic [63:0] exp_mem [16];

    typedef struct {
        logic        start;
        logic        stall;
        logic [4:0]  n;
        logic [7:0]  loops;
        logic        e_busy;
        logic        e_done;
        logic        e_v;
        logic [63:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    inst_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_v    (load_v),
        .load_addr (load_addr),
        .load_inst (load_inst),
        .start     (start),
        .num_inst  (num_inst),
        .num_loops (num_loops),
        .stall     (stall),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .inst_v    (inst_v),
        .inst      (inst)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic st, input logic [4:0] n,
                                input logic [7:0] l, input logic b, input logic d,
                                input logic v, input logic [63:0] i);
        vec_t r;
        r.start = s; r.stall = st; r.n = n; r.loops = l;
        r.e_busy = b; r.e_done = d; r.e_v = v; r.e_inst = i;
        return r;
    endfunction

    task automatic load(input int addr, input logic [63:0] data);
        load_v    = 1'b1;
        load_addr = 4'(addr);
        load_inst = data;
        step();
        load_v    = 1'b0;
    endtask

    // Runs one program, checking issue order, count, contiguity and a single done.
    task automatic run_prog(input string name, input int n, input int loops, input bit meddle);
        int per, total, issued, dones, bad, busy_bad, first, lastc, extra;
        per = (n > 16) ? 16 : n;
        total = per * (loops + 1);
        issued = 0; dones = 0; bad = 0; busy_bad = 0; first = -1; lastc = -1; extra = 0;
        start = 1'b1; num_inst = 5'(n); num_loops = 8'(loops);
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 600 && dones == 0; cyc++) begin
            if (meddle && cyc == 2) begin
                load_v = 1'b1; load_addr = 4'd0; load_inst = 64'hDEAD_BEEF_0000_0000;
                start = 1'b1;
            end
            step();
            load_v = 1'b0;
            start  = 1'b0;
            if (inst_v) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                if (issued >= total || inst !== exp_mem[issued % per]) bad++;
                issued++;
            end
            if (done) dones++;
            else if (!busy) busy_bad++;
        end
        for (int k = 0; k < 8; k++) begin
            step();
            if (done || inst_v || busy) extra++;
        end
        chk({name, "_issues"}, 64'(issued), 64'(total));
        chk({name, "_order"}, 64'(bad), 64'd0);
        chk({name, "_contig"}, 64'(lastc - first + 1), 64'(issued));
        chk({name, "_done"}, 64'(dones), 64'd1);
        chk({name, "_busy"}, 64'(busy_bad), 64'd0);
        chk({name, "_quiet"}, 64'(extra), 64'd0);
    endtask

    initial begin
        int seen_v, seen_done;
        rst_n = 1'b0; load_v = 1'b0; load_addr = '0; load_inst = '0;
        start = 1'b0; num_inst = '0; num_loops = '0; stall = 1'b0; abort = 1'b0;
        step(); step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_inst_v", 64'(inst_v), 64'd0);
        chk("reset_inst", inst, 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) exp_mem[i] = {1'b1, 31'(i), 5'd0, 3'(i), 24'(i * 17)};
        exp_mem[0] = ADD; exp_mem[1] = SUB; exp_mem[2] = MUL;
        for (int i = 0; i < 16; i++) load(i, exp_mem[i]);

        // Basic three-instruction program
        vecs.push_back(mk(1, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 1, ADD));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 1, SUB));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 1, MUL));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0));
        // Two-cycle stall on the second issue, stall in drain, start on last drain edge
        vecs.push_back(mk(1, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 1, ADD));
        vecs.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 1, SUB));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 1, MUL));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0));
        // Zero-length program
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stall = vecs[i].stall;
            num_inst = vecs[i].n; num_loops = vecs[i].loops;
            step();
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].e_done));
            chk($sformatf("vec%0d_inst_v", i), 64'(inst_v), 64'(vecs[i].e_v));
            if (vecs[i].e_v) chk($sformatf("vec%0d_inst", i), inst, vecs[i].e_inst);
        end
        start = 1'b0; stall = 1'b0;

        run_prog("loops", 2, 3, 1'b0);
        run_prog("clamp", 20, 0, 1'b0);
        run_prog("meddle", 3, 1, 1'b1);
        run_prog("readback", 3, 0, 1'b0);

        // Abort on the fourth issue edge of a 16-instruction program
        start = 1'b1; num_inst = 5'd16; num_loops = 8'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort_pre%0d_v", k), 64'(inst_v), 64'd1);
            chk($sformatf("abort_pre%0d_inst", k), inst, exp_mem[k]);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_inst_v", 64'(inst_v), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        seen_v = 0; seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (inst_v) seen_v++;
            if (done) seen_done++;
        end
        chk("abort_after_v", 64'(seen_v), 64'd0);
        chk("abort_after_done", 64'(seen_done), 64'd0);

        // Reset mid-program behaves like abort and keeps the buffer
        start = 1'b1; num_inst = 5'd16; num_loops = 8'd0;
        step();
        start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_inst_v", 64'(inst_v), 64'd0);
        chk("midrst_inst", inst, 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();

        run_prog("restart", 16, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
